// File: rtl/mc_ctrl_pkg.sv
// Shared constants and decoded-field types for the multi-cycle controller.
// Holds FSM state codes, opcode/funct codes, output encodings, the instruction class enum
// and the decoded-field struct. Optional MDU support is compiled in with MC_CTRL_MDU_EN.
package mc_ctrl_pkg;

    // FSM state codes; the numeric values are visible on the debug state output.
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
`ifdef MC_CTRL_MDU_EN
    localparam logic [2:0] ST_MDU    = 3'd6;
`endif

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
`ifdef MC_CTRL_MDU_EN
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;
`endif

    // Register-file write data select
    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;
    localparam logic [1:0] WSEL_LUI = 2'b11;

    // Destination-register format
    localparam logic [1:0] ITYPE_R  = 2'd0;
    localparam logic [1:0] ITYPE_I  = 2'd1;
    localparam logic [1:0] ITYPE_J  = 2'd2;

    // Next-PC source
    localparam logic [2:0] JSIG_SEQ = 3'd0;
    localparam logic [2:0] JSIG_BEQ = 3'd1;
    localparam logic [2:0] JSIG_JAL = 3'd2;
    localparam logic [2:0] JSIG_JR  = 3'd3;

    // ALU operation
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;

    // Instruction class: decides the FSM path, independent of the datapath encodings.
    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_JAL,
        CLS_JR
`ifdef MC_CTRL_MDU_EN
        , CLS_MDU
`endif
    } cls_e;

    typedef struct packed {
        cls_e       cls;
        logic [1:0] itype;
        logic [2:0] jsig;
        logic [1:0] wsel;
        logic [2:0] aop;
    } dec_t;

    // Classes whose PC update happens in DECODE (no EXEC phase).
    function automatic logic pc_in_decode(input cls_e c);
        return (c == CLS_NOP) || (c == CLS_JAL) || (c == CLS_JR);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Bundle between the datapath and the multi-cycle controller.
// master: datapath side (drives IR fields and flags, receives strobes and selects).
// slave: controller side. mdu_busy exists only when MC_CTRL_MDU_EN is defined.
interface mc_ctrl_if;
    // datapath -> controller
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
`ifdef MC_CTRL_MDU_EN
    logic       mdu_busy;
`endif
    // controller -> datapath
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic [1:0] instruct_type;
    logic [2:0] jump_signal;
    logic [1:0] grf_write_sel;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       bus_err;

    modport master (
        output opcode, funct, alu_zero, mem_ready,
`ifdef MC_CTRL_MDU_EN
        output mdu_busy,
`endif
        input  pc_we, ir_we, reg_we, mem_we, instruct_type, jump_signal,
               grf_write_sel, alu_op, state, bus_err
    );

    modport slave (
        input  opcode, funct, alu_zero, mem_ready,
`ifdef MC_CTRL_MDU_EN
        input  mdu_busy,
`endif
        output pc_we, ir_we, reg_we, mem_we, instruct_type, jump_signal,
               grf_write_sel, alu_op, state, bus_err
    );
endinterface

// File: rtl/mc_decode.sv
// Instruction decoder: maps opcode/funct to instruction class and datapath encodings.
// Latency: purely combinational, zero cycles.
// Backpressure: none; unknown opcode/funct pairs decode as a nop with all fields zero.
// Ports: opcode, funct (IR fields) in; dec (class + encoded fields) out.
// MC_CTRL_MDU_EN adds mult/div as the MDU class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        dec.cls   = CLS_ALU;
                        dec.itype = ITYPE_R;
                        dec.aop   = ALU_ADD;
                    end
                    FN_SUBU: begin
                        dec.cls   = CLS_ALU;
                        dec.itype = ITYPE_R;
                        dec.aop   = ALU_SUB;
                    end
                    FN_JR: begin
                        dec.cls   = CLS_JR;
                        dec.jsig  = JSIG_JR;
                    end
`ifdef MC_CTRL_MDU_EN
                    FN_MULT, FN_DIV: begin
                        dec.cls   = CLS_MDU;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec.cls   = CLS_ALU;
                dec.itype = ITYPE_I;
                dec.aop   = ALU_OR;
            end
            OP_LW: begin
                dec.cls   = CLS_LW;
                dec.itype = ITYPE_I;
                dec.wsel  = WSEL_MEM;
                dec.aop   = ALU_ADD;
            end
            OP_SW: begin
                dec.cls   = CLS_SW;
                dec.itype = ITYPE_I;
                dec.aop   = ALU_ADD;
            end
            OP_BEQ: begin
                dec.cls   = CLS_BEQ;
                dec.itype = ITYPE_I;
                dec.jsig  = JSIG_BEQ;
                dec.aop   = ALU_SUB;
            end
            OP_LUI: begin
                dec.cls   = CLS_LUI;
                dec.itype = ITYPE_I;
                dec.wsel  = WSEL_LUI;
            end
            OP_JAL: begin
                dec.cls   = CLS_JAL;
                dec.itype = ITYPE_J;
                dec.jsig  = JSIG_JAL;
                dec.wsel  = WSEL_PC;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM with sticky memory timeout.
// Latency: strobes are Moore outputs of the state (sw completion pc_we follows mem_ready same cycle).
// Backpressure: MEM stalls on mem_ready up to MEM_WAIT_MAX cycles, then bus_err and HALT until reset.
// Ports: clk, rst_n (async, active-low) and bus (mc_ctrl_if.slave): opcode/funct/alu_zero/mem_ready in;
//        pc_we/ir_we/reg_we/mem_we, instruct_type, jump_signal, grf_write_sel, alu_op, state, bus_err out.
// Optional macro MC_CTRL_MDU_EN: MDU state, mult/div decode and bus.mdu_busy.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int          MEM_WAIT_MAX = 16,
    parameter logic [31:0] PC_RESET     = 32'h0000_3000
)(
    input  logic    clk,
    input  logic    rst_n,
    mc_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    // The PC register itself lives in the datapath; its reset value is only sanity-checked here.
    if (MEM_WAIT_MAX < 1) begin : g_bad_wait
        $error("mc_ctrl: MEM_WAIT_MAX must be at least 1");
    end
    if (PC_RESET[1:0] != 2'b00) begin : g_bad_pc
        $error("mc_ctrl: PC_RESET must be word aligned");
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    dec_t             dec, dec_q;
    logic             pc_we_c, ir_we_c, reg_we_c, mem_we_c;
    logic             in_decode;

    mc_decode u_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .dec    (dec)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_we_c = 1'b1;
                state_d = ST_DECODE;
            end
            // Classification comes from the live IR here; dec_q captures it on the way out.
            ST_DECODE: begin
                if (pc_in_decode(dec.cls)) begin
                    pc_we_c = 1'b1;
                    state_d = (dec.cls == CLS_JAL) ? ST_WB : ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (dec_q.cls)
                    CLS_BEQ: begin
                        pc_we_c = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_LW, CLS_SW: begin
                        cnt_d   = '0;
                        state_d = ST_MEM;
                    end
`ifdef MC_CTRL_MDU_EN
                    CLS_MDU: state_d = ST_MDU;
`endif
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_we_c = (dec_q.cls == CLS_SW);
                // mem_ready is checked first so it wins over a coincident timeout.
                if (bus.mem_ready) begin
                    if (dec_q.cls == CLS_SW) begin
                        pc_we_c = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (cnt_q == CNT_W'(MEM_WAIT_MAX - 1)) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
                // jal already moved the PC in DECODE.
                pc_we_c  = (dec_q.cls != CLS_JAL);
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef MC_CTRL_MDU_EN
            ST_MDU: begin
                if (!bus.mdu_busy) begin
                    pc_we_c = 1'b1;
                    state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            dec_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            if (state_q == ST_DECODE) begin
                dec_q <= dec;
            end
        end
    end

    // Strobes are gated by rst_n so an asserted reset silences them without waiting for a clock,
    // even though the reset state (FETCH) would otherwise raise ir_we.
    assign bus.pc_we  = pc_we_c  & rst_n;
    assign bus.ir_we  = ir_we_c  & rst_n;
    assign bus.reg_we = reg_we_c & rst_n;
    assign bus.mem_we = mem_we_c & rst_n;

    // In DECODE the datapath already needs the jal/jr selects, before dec_q is loaded.
    assign in_decode         = (state_q == ST_DECODE);
    assign bus.instruct_type = in_decode ? dec.itype : dec_q.itype;
    assign bus.jump_signal   = in_decode ? dec.jsig  : dec_q.jsig;
    assign bus.grf_write_sel = in_decode ? dec.wsel  : dec_q.wsel;
    assign bus.alu_op        = in_decode ? dec.aop   : dec_q.aop;
    assign bus.state         = state_q;
    assign bus.bus_err       = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction streams.
// Each instruction is expanded by a reference model into its expected per-cycle behaviour.
// Random mid-instruction resets and memory timeouts are mixed in.
module tb_mc_ctrl;

    localparam int WAIT = 16;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4,
                   K_BEQ  = 5, K_LUI  = 6, K_JAL = 7, K_JR = 8, K_NOP = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl #(.MEM_WAIT_MAX(WAIT), .PC_RESET(32'h0000_3000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One expected cycle: state, strobes {pc,ir,reg,mem}, bus_err, mem_ready to drive,
    // whether the IR still holds the instruction, whether the encoded fields are checked.
    typedef struct packed {
        logic [2:0] st;
        logic [3:0] stb;
        logic       berr;
        logic       rdy;
        logic       hold_ir;
        logic       fchk;
    } cyc_t;

    cyc_t q[$];

    function automatic void push(input logic [2:0] st, input logic [3:0] stb, input logic berr,
                                 input logic rdy, input logic hold_ir, input logic fchk);
        cyc_t c;
        c.st = st; c.stb = stb; c.berr = berr; c.rdy = rdy; c.hold_ir = hold_ir; c.fchk = fchk;
        q.push_back(c);
    endfunction

    // {instruct_type[1:0], jump_signal[2:0], grf_write_sel[1:0], alu_op[2:0]}
    function automatic logic [9:0] exp_fields(input int k);
        case (k)
            K_ADDU:  return {2'd0, 3'd0, 2'b00, 3'd0};
            K_SUBU:  return {2'd0, 3'd0, 2'b00, 3'd1};
            K_ORI:   return {2'd1, 3'd0, 2'b00, 3'd2};
            K_LW:    return {2'd1, 3'd0, 2'b01, 3'd0};
            K_SW:    return {2'd1, 3'd0, 2'b00, 3'd0};
            K_BEQ:   return {2'd1, 3'd1, 2'b00, 3'd1};
            K_LUI:   return {2'd1, 3'd0, 2'b11, 3'd0};
            K_JAL:   return {2'd2, 3'd2, 2'b10, 3'd0};
            K_JR:    return {2'd0, 3'd3, 2'b00, 3'd0};
            default: return 10'd0;
        endcase
    endfunction

    task automatic make_instr(input int k, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] r;
        op = 6'h00;
        fn = 6'($urandom);
        case (k)
            K_ADDU: fn = 6'h21;
            K_SUBU: fn = 6'h23;
            K_JR:   fn = 6'h08;
            K_ORI:  op = 6'h0d;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2b;
            K_BEQ:  op = 6'h04;
            K_LUI:  op = 6'h0f;
            K_JAL:  op = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    // R-type with an unsupported funct (mult/div included)
                    case ($urandom_range(0, 2))
                        0:       fn = 6'h18;
                        1:       fn = 6'h1a;
                        default: begin
                            r = 6'($urandom);
                            while (r == 6'h21 || r == 6'h23 || r == 6'h08) r = 6'($urandom);
                            fn = r;
                        end
                    endcase
                end else begin
                    r = 6'($urandom);
                    while (r == 6'h00 || r == 6'h03 || r == 6'h04 || r == 6'h0d ||
                           r == 6'h0f || r == 6'h23 || r == 6'h2b) r = 6'($urandom);
                    op = r;
                end
            end
        endcase
    endtask

    // Reference model: expected cycle sequence of one instruction. lat = MEM cycle (1-based)
    // in which mem_ready is high; beyond WAIT means it never arrives in time.
    function automatic void build(input int k, input int lat);
        logic dec_pc, r, is_sw;
        q.delete();
        push(3'd0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        dec_pc = (k == K_JAL || k == K_JR || k == K_NOP);
        push(3'd1, {dec_pc, 3'b000}, 1'b0, 1'b0, 1'b1, 1'b1);
        if (k == K_JAL) begin
            push(3'd4, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
            return;
        end
        if (k == K_JR || k == K_NOP) return;
        push(3'd2, {k == K_BEQ, 3'b000}, 1'b0, 1'b0, 1'b0, 1'b1);
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            is_sw = (k == K_SW);
            for (int i = 0; i < WAIT; i++) begin
                r = (i == lat - 1);
                push(3'd3, {is_sw & r, 1'b0, 1'b0, is_sw}, 1'b0, r, 1'b0, 1'b1);
                if (r) break;
            end
            if (lat > WAIT) begin
                for (int i = 0; i < 4; i++) push(3'd5, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (is_sw) return;
        end
        push(3'd4, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic chk_reset();
        chk("rst_state",   {29'd0, bus.state}, 32'd0);
        chk("rst_strobes", {28'd0, bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we}, 32'd0);
        chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
        chk("rst_fields",  {22'd0, bus.instruct_type, bus.jump_signal, bus.grf_write_sel,
                            bus.alu_op}, 32'd0);
    endtask

    // abort: -1 none, -2 random point, otherwise record index at which reset is pulled.
    // A timeout always ends in reset on the last HALT cycle.
    task automatic run(input int k, input int lat, input int abort);
        logic [5:0] op, fn;
        int ab;
        cyc_t c;
        make_instr(k, op, fn);
        build(k, lat);
        ab = abort;
        if (abort == -2) ab = $urandom_range(0, q.size() - 1);
        if ((k == K_LW || k == K_SW) && lat > WAIT) ab = q.size() - 1;
        for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            @(negedge clk);
            rst_n = 1'b1;
            bus.alu_zero = 1'($urandom);
            bus.mem_ready = (c.st == 3'd3) ? c.rdy : 1'($urandom);
            if (c.hold_ir) begin
                bus.opcode = op;
                bus.funct  = fn;
            end else begin
                bus.opcode = 6'($urandom);
                bus.funct  = 6'($urandom);
            end
            #1;
            chk("state",   {29'd0, bus.state}, {29'd0, c.st});
            chk("strobes", {28'd0, bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we}, {28'd0, c.stb});
            chk("bus_err", {31'd0, bus.bus_err}, {31'd0, c.berr});
            if (c.fchk)
                chk("fields", {22'd0, bus.instruct_type, bus.jump_signal, bus.grf_write_sel,
                               bus.alu_op}, {22'd0, exp_fields(k)});
            if (i == ab) begin
                rst_n = 1'b0;
                #1;
                chk_reset();
                @(posedge clk);
                break;
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk_reset();
        repeat (2) @(posedge clk);

        run(K_LUI,  0,  -1);
        run(K_LW,   3,  -1);
        run(K_LW,   16, -1);
        run(K_SW,   99, -1);
        run(K_JAL,  0,  -1);
        run(K_ADDU, 0,   3);
        run(K_SW,   1,  -1);
        run(K_BEQ,  0,  -1);
        run(K_JR,   0,  -1);
        run(K_NOP,  0,  -1);
        run(K_ORI,  0,  -1);
        run(K_SUBU, 0,  -1);
        run(K_LW,   17, -1);

        repeat (250) begin
            int k, lat, ab;
            k   = $urandom_range(0, 9);
            lat = $urandom_range(1, 20);
            ab  = ($urandom_range(0, 7) == 0) ? -2 : -1;
            run(k, lat, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 16: maximum cycles spent in MEM waiting for mem_ready before flagging a bus error.
REQ-002 SHALL have parameter PC_RESET, default 32'h0000_3000: PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port opcode, input, 6: instruction bits [31:26] from IR.
REQ-006 SHALL have port funct, input, 6: instruction bits [5:0] from IR.
REQ-007 SHALL have port alu_zero, input, 1: ALU equal flag, used by beq.
REQ-008 SHALL have port mem_ready, input, 1: data memory completion handshake.
REQ-009 SHALL have outputs pc_we, ir_we, reg_we, mem_we, each 1 bit: state-element write strobes.
REQ-010 SHALL have output instruct_type, 2: 0 = R (write rd), 1 = I (write rt), 2 = J.
REQ-011 SHALL have output jump_signal, 3: 0 = seq, 1 = beq, 2 = jal, 3 = jr.
REQ-012 SHALL have output grf_write_sel, 2: 00 ALUOut, 01 MemOut, 10 PC return, 11 lui.
REQ-013 SHALL have output alu_op, 3: 0 add, 1 sub, 2 or.
REQ-014 SHALL have output state, 3: current FSM state, for debug.
REQ-015 SHALL have output bus_err, 1: sticky memory timeout flag.

Function
REQ-016 SHALL decode addu, subu, jr (opcode 0), ori, lw, sw, beq, lui and jal; any other opcode/funct SHALL be treated as nop.
REQ-017 SHALL run FSM states FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5).
REQ-018 FETCH: ir_we=1 for exactly one cycle, then go to DECODE.
REQ-019 DECODE: jal and jr SHALL assert pc_we and go to WB (jal) or FETCH (jr); nop SHALL pulse pc_we and go to FETCH; all others go to EXEC.
REQ-020 EXEC: beq SHALL pulse pc_we (the datapath selects the target when alu_zero=1, else PC+4) and go to FETCH; lw/sw go to MEM; ALU ops and lui go to WB.
REQ-021 MEM: sw SHALL hold mem_we=1 until mem_ready is sampled high; lw SHALL wait for mem_ready, then go to WB; sw SHALL then pulse pc_we and go to FETCH.
REQ-022 MEM wait counter SHALL clear on MEM entry; if it reaches MEM_WAIT_MAX without mem_ready, the FSM SHALL set bus_err and enter HALT.
REQ-023 mem_ready and the timeout arriving in the same cycle: mem_ready SHALL win.
REQ-024 WB: reg_we=1 for one cycle; pc_we=1 except for jal (PC already updated in DECODE); then go to FETCH.
REQ-025 grf_write_sel: ALU ops 00, lw 01, jal 10, lui 11; instruct_type: R-type 0, ori/lw/lui 1, jal 2.
REQ-026 Only one writing strobe in {reg_we, mem_we} SHALL be high in any cycle; ir_we SHALL never coincide with reg_we.
REQ-027 HALT SHALL be absorbing until reset, with all strobes low.
REQ-028 Decoded fields SHALL be registered in DECODE and held stable through WB, independent of later IR changes.

Reset
REQ-029 rst_n low SHALL immediately force: state=FETCH, all strobes=0, bus_err=0, counter=0, encoded outputs=0.
REQ-030 Reset asserted mid-MEM or mid-WB SHALL abort without any further write strobe; the first post-reset cycle SHALL be FETCH.

Configuration
REQ-031 With MC_CTRL_MDU_EN defined: add state MDU(6), decode mult/div (opcode 0, funct 0x18/0x1A), and input mdu_busy; EXEC goes to MDU, which waits for !mdu_busy and then returns to FETCH with pc_we. Without the macro: no MDU state or port, and these instructions decode as nop.

Structure
REQ-032 A shared package SHALL hold the state, opcode/funct, grf_write_sel, instruct_type, jump_signal and alu_op constants.
REQ-033 A combinational sub-module mc_decode SHALL map opcode/funct to the class and encoded fields; mc_ctrl SHALL hold the FSM, the registers and the counter.

Verification
REQ-034 Sequence lui $1,0x1234: FETCH->DECODE->EXEC->WB; in WB, reg_we=1, grf_write_sel=11, instruct_type=1.
REQ-035 lw with mem_ready rising on the third MEM cycle: MEM is held 3 cycles, then WB with grf_write_sel=01.
REQ-036 sw with mem_ready never asserted and MEM_WAIT_MAX=16: bus_err=1 after 16 MEM cycles, state=5, strobes stay 0.
REQ-037 jal: pc_we in DECODE; WB has reg_we=1, grf_write_sel=10, instruct_type=2, jump_signal=2, pc_we=0.
REQ-038 rst_n pulled low in WB of addu: reg_we falls without a clock edge; after release, state=0 and ir_we=1.
